// File: rtl/rr_sel_mux.sv
`default_nettype none
// ============================================================================
//  Module   : rr_sel_mux
//  Purpose  : NCH-channel selector with forced-select and round-robin grant
//             modes, feeding one registered valid/ready output slot.
//  Revision : 1.0  initial release
// ============================================================================
module rr_sel_mux #(
    parameter int WIDTH = 5,
    parameter int NCH   = 4,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    input  logic                   mode,
    input  logic [SELW-1:0]        force_sel,
    output logic [WIDTH-1:0]       out_data,
    output logic [SELW-1:0]        out_ch,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam logic [SELW:0] c_nch = (SELW+1)'(NCH);

    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic [SELW-1:0]     r_out_ch;
    logic [SELW-1:0]     r_last_ch;

    logic                w_load_en;
    logic                w_xfer;
    logic                w_grant_valid;
    logic [SELW-1:0]     w_grant;
    logic [WIDTH-1:0]    w_grant_data;

    logic                w_force_valid;
    logic [SELW-1:0]     w_force_grant;
    logic [SELW:0]       w_shift;
    logic [2*NCH-1:0]    w_dbl;
    logic [NCH-1:0]      w_rot;
    logic                w_rr_valid;
    logic [SELW-1:0]     w_rr_off;
    logic [SELW:0]       w_rr_sum;
    logic [SELW-1:0]     w_rr_grant;

    assign w_load_en = !r_out_valid || out_ready;

    // A force_sel beyond the last channel simply matches nothing.
    always_comb begin
        w_force_valid = 1'b0;
        w_force_grant = '0;
        for (int i = 0; i < NCH; i++) begin
            if (force_sel == SELW'(i) && in_valid[i]) begin
                w_force_valid = 1'b1;
                w_force_grant = SELW'(i);
            end
        end
    end

    // Rotate requests so bit 0 is the channel just after the last grant,
    // then take the lowest set bit as the offset from that starting point.
    always_comb begin
        w_shift    = {1'b0, r_last_ch} + (SELW+1)'(1);
        w_dbl      = {in_valid, in_valid} >> w_shift;
        w_rot      = w_dbl[NCH-1:0];
        w_rr_valid = |w_rot;
        w_rr_off   = '0;
        for (int j = NCH-1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_rr_off = SELW'(j);
            end
        end
        w_rr_sum   = w_shift + {1'b0, w_rr_off};
        w_rr_grant = (w_rr_sum >= c_nch) ? SELW'(w_rr_sum - c_nch) : SELW'(w_rr_sum);
    end

    always_comb begin
        w_grant_valid = mode ? w_rr_valid : w_force_valid;
        w_grant       = mode ? w_rr_grant : w_force_grant;
    end

    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_grant == SELW'(i)) begin
                w_grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_xfer = !rst && w_load_en && w_grant_valid;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
            assign in_ready[gi] = w_xfer && (w_grant == SELW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_last_ch   <= SELW'(NCH-1);
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_grant_data;
            r_out_ch    <= w_grant;
            if (mode) begin
                r_last_ch <= w_grant;
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

endmodule
`default_nettype wire
